// File: rtl/ray_march_step_ctrl.sv
`timescale 1ns/1ps
// ray_march_step_ctrl: sphere-tracing controller, one SDF evaluation in flight per step.
// vec3 ports are packed {z, y, x}; every component is an N-bit signed fixed-point word.
module ray_march_step_ctrl #(
    parameter int N         = 32,
    parameter int FRAC_BITS = 24,
    parameter int MAX_STEPS = 64,
    parameter int HIT_EPS   = 16777,
    parameter int MAX_DIST  = 335544320
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [3*N-1:0]                 ray_origin,
    input  logic [3*N-1:0]                 ray_dir,
    output logic                           sdf_req_valid,
    output logic [3*N-1:0]                 sdf_pos,
    input  logic                           sdf_dist_valid,
    input  logic [N-1:0]                   sdf_dist,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic                           hit,
    output logic [$clog2(MAX_STEPS+1)-1:0] step_count,
    output logic [N-1:0]                   total_dist,
    output logic [3*N-1:0]                 hit_pos
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] STEP = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic signed [N-1:0] EPS_Q    = N'(HIT_EPS);
    localparam logic signed [N-1:0] FAR_Q    = N'(MAX_DIST);
    localparam logic [SW-1:0]       STEP_LIM = SW'(MAX_STEPS);

    // Every addition on the ray clamps to the signed range instead of wrapping.
    function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1])
            return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        return s[N-1:0];
    endfunction

    function automatic logic signed [N-1:0] fp_mul(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        logic signed [2*N-1:0] prod;
        prod = (2*N)'(a) * (2*N)'(b);
        prod = prod >>> FRAC_BITS;
        return prod[N-1:0];
    endfunction

    logic [2:0]          state;
    logic signed [N-1:0] px, py, pz;
    logic signed [N-1:0] dx, dy, dz;
    logic signed [N-1:0] t;
    logic signed [N-1:0] d;
    logic [SW-1:0]       steps;

    logic [SW-1:0]       steps_inc;
    logic signed [N-1:0] t_probe;
    logic                is_hit;
    logic                give_up;

    assign start_ready = (state == IDLE);
    assign steps_inc   = steps + SW'(1);
    assign t_probe     = sat_add(t, $signed(sdf_dist));
    assign is_hit      = $signed(sdf_dist) < EPS_Q;
    assign give_up     = (steps_inc == STEP_LIM) || (t_probe >= FAR_Q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sdf_req_valid <= 1'b0;
            result_valid  <= 1'b0;
            hit           <= 1'b0;
            step_count    <= '0;
            total_dist    <= '0;
            sdf_pos       <= '0;
            hit_pos       <= '0;
            px            <= '0;
            py            <= '0;
            pz            <= '0;
            dx            <= '0;
            dy            <= '0;
            dz            <= '0;
            t             <= '0;
            d             <= '0;
            steps         <= '0;
        end else begin
            sdf_req_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        px    <= ray_origin[N-1:0];
                        py    <= ray_origin[2*N-1:N];
                        pz    <= ray_origin[3*N-1:2*N];
                        dx    <= ray_dir[N-1:0];
                        dy    <= ray_dir[2*N-1:N];
                        dz    <= ray_dir[3*N-1:2*N];
                        t     <= '0;
                        steps <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    sdf_req_valid <= 1'b1;
                    sdf_pos       <= {pz, py, px};
                    state         <= WAIT;
                end
                WAIT: begin
                    // A hit outranks both the step limit and the far limit.
                    if (sdf_dist_valid) begin
                        d     <= $signed(sdf_dist);
                        steps <= steps_inc;
                        if (is_hit || give_up) begin
                            hit          <= is_hit;
                            result_valid <= 1'b1;
                            hit_pos      <= {pz, py, px};
                            total_dist   <= t;
                            step_count   <= steps_inc;
                            state        <= DONE;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                STEP: begin
                    px    <= sat_add(px, fp_mul(dx, d));
                    py    <= sat_add(py, fp_mul(dy, d));
                    pz    <= sat_add(pz, fp_mul(dz, d));
                    t     <= sat_add(t, d);
                    state <= REQ;
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_march_step_ctrl.sv
`timescale 1ns/1ps
// tb_ray_march_step_ctrl: scoreboard bench with an SDF responder, directed rays and random rays
// checked against a plain-arithmetic sphere-tracing model.
module tb_ray_march_step_ctrl;

    localparam int MAXS = 64;
    localparam int EPS  = 16777;
    localparam int FAR  = 335544320;
    localparam int ONE  = 1 << 24;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic        hit;
        logic [6:0]  steps;
        logic [31:0] tdist;
        logic [95:0] hpos;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [95:0] ray_origin;
    logic [95:0] ray_dir;
    logic        sdf_req_valid;
    logic [95:0] sdf_pos;
    logic        sdf_dist_valid;
    logic [31:0] sdf_dist;
    logic        result_valid;
    logic        result_ready;
    logic        hit;
    logic [6:0]  step_count;
    logic [31:0] total_dist;
    logic [95:0] hit_pos;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   dist_q[$];
    int   dlist[MAXS];
    bit   resp_en = 1'b1;
    bit   sphere_mode = 1'b0;
    int   req_total = 0;

    always #5 clk = ~clk;

    ray_march_step_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .ray_origin     (ray_origin),
        .ray_dir        (ray_dir),
        .sdf_req_valid  (sdf_req_valid),
        .sdf_pos        (sdf_pos),
        .sdf_dist_valid (sdf_dist_valid),
        .sdf_dist       (sdf_dist),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .hit            (hit),
        .step_count     (step_count),
        .total_dist     (total_dist),
        .hit_pos        (hit_pos)
    );

    function automatic logic [95:0] vec(input int x, input int y, input int z);
        return {z, y, x};
    endfunction

    function automatic longint sat32(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        longint pr;
        int     tr;
        pr = (a * b) >>> 24;
        tr = int'(pr);
        return longint'(tr);
    endfunction

    // Sphere tracing as described: walk dlist until hit, step limit or far limit.
    function automatic exp_t model_run(input logic [95:0] org, input logic [95:0] dir);
        exp_t   e;
        longint p[3];
        longint v[3];
        longint t;
        int     d;
        for (int k = 0; k < 3; k++) begin
            p[k] = longint'($signed(org[32*k +: 32]));
            v[k] = longint'($signed(dir[32*k +: 32]));
        end
        t = 0;
        e.hit = 1'b0;
        e.steps = 7'd0;
        for (int i = 0; i < MAXS; i++) begin
            d = dlist[i];
            e.steps = 7'(i + 1);
            if (d < EPS) begin
                e.hit = 1'b1;
                break;
            end
            if (i + 1 == MAXS || sat32(t + d) >= FAR) break;
            for (int k = 0; k < 3; k++) p[k] = sat32(p[k] + qmul(v[k], d));
            t = sat32(t + d);
        end
        e.tdist = t[31:0];
        e.hpos  = {p[2][31:0], p[1][31:0], p[0][31:0]};
        return e;
    endfunction

    function automatic int sphere_d(input logic [95:0] v);
        real x, y, z, r;
        x = $itor($signed(v[31:0])) / 16777216.0;
        y = $itor($signed(v[63:32])) / 16777216.0;
        z = $itor($signed(v[95:64])) / 16777216.0;
        r = $sqrt(x*x + y*y + z*z) - 1.0;
        return $rtoi(r * 16777216.0);
    endfunction

    function automatic int rand_dist();
        case ($urandom_range(0, 9))
            0: return int'($urandom_range(0, EPS - 1));
            1: return -int'($urandom_range(1, ONE));
            2: return int'($urandom_range(5*ONE, 127*ONE));
            3: return EPS;
            default: return int'($urandom_range(ONE/4, 3*ONE));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_start_ready"}, 96'(start_ready), 96'(1));
        checkOutput({tag, "_sdf_req_valid"}, 96'(sdf_req_valid), 96'(0));
        checkOutput({tag, "_result_valid"}, 96'(result_valid), 96'(0));
        checkOutput({tag, "_hit"}, 96'(hit), 96'(0));
        checkOutput({tag, "_step_count"}, 96'(step_count), 96'(0));
        checkOutput({tag, "_total_dist"}, 96'(total_dist), 96'(0));
        checkOutput({tag, "_sdf_pos"}, sdf_pos, 96'(0));
        checkOutput({tag, "_hit_pos"}, hit_pos, 96'(0));
    endtask

    task automatic applyStimulus(input logic [95:0] org, input logic [95:0] dir);
        int n = 0;
        @(negedge clk);
        while (!start_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            checkOutput("start_ready_timeout", 96'(start_ready), 96'(1));
            return;
        end
        ray_origin  = org;
        ray_dir     = dir;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drain", 96'(exp_q.size()), 96'(0));
    endtask

    // SDF pipe stand-in: one response per request after 1..4 cycles (3 for the sphere).
    initial begin
        int lat;
        int dv;
        sdf_dist_valid = 1'b0;
        sdf_dist = '0;
        forever begin
            @(negedge clk);
            if (resp_en && sdf_req_valid) begin
                req_total++;
                if (sphere_mode) begin
                    dv  = sphere_d(sdf_pos);
                    lat = 3;
                end else begin
                    lat = int'($urandom_range(1, 4));
                    if (dist_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("[TB] FAIL extra_sdf_request: got request at %h expected none", sdf_pos);
                        dv = 0;
                    end else begin
                        dv = dist_q.pop_front();
                    end
                end
                repeat (lat - 1) @(negedge clk);
                sdf_dist_valid = 1'b1;
                sdf_dist = dv;
                @(negedge clk);
                sdf_dist_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compare every accepted result against the oldest expectation.
    initial begin
        int   req_mark = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_result: got result hit=%0d steps=%0d expected none", hit, step_count);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("hit", 96'(hit), 96'(e.hit));
                    checkOutput("step_count", 96'(step_count), 96'(e.steps));
                    checkOutput("total_dist", 96'(total_dist), 96'(e.tdist));
                    checkOutput("hit_pos", hit_pos, e.hpos);
                    checkOutput("sdf_requests", 96'(req_total - req_mark), 96'(e.steps));
                end
                req_mark = req_total;
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   req0;
        int   n;
        logic [95:0] org;
        logic [95:0] dir;

        rst = 1'b1;
        start_valid = 1'b0;
        ray_origin = '0;
        ray_dir = '0;
        result_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] sphere ray from (0,0,-5)");
        sphere_mode = 1'b1;
        exp_q.push_back('{1'b1, 7'd2, 32'h04000000, vec(0, 0, -ONE)});
        applyStimulus(vec(0, 0, -5*ONE), vec(0, 0, ONE));
        waitDrain();
        sphere_mode = 1'b0;

        $display("[TB] constant d=3.0, far limit");
        for (int i = 0; i < 7; i++) dist_q.push_back(3*ONE);
        exp_q.push_back('{1'b0, 7'd7, 32'h12000000, vec(0, 0, 18*ONE)});
        applyStimulus(vec(0, 0, 0), vec(0, 0, ONE));
        waitDrain();

        $display("[TB] constant d=0.01, step limit");
        for (int i = 0; i < 64; i++) dist_q.push_back(167772);
        exp_q.push_back('{1'b0, 7'd64, 32'd10569636, vec(0, 0, 10569636)});
        applyStimulus(vec(0, 0, 0), vec(0, 0, ONE));
        waitDrain();

        $display("[TB] negative first distance, result held for 10 cycles");
        result_ready = 1'b0;
        dist_q.push_back(-(ONE/2));
        e = '{1'b1, 7'd1, 32'd0, vec(ONE, 2*ONE, 3*ONE)};
        exp_q.push_back(e);
        applyStimulus(vec(ONE, 2*ONE, 3*ONE), vec(0, ONE, 0));
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_result_valid", 96'(result_valid), 96'(1));
        req0 = req_total;
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_hit", 96'(hit), 96'(e.hit));
            checkOutput("hold_step_count", 96'(step_count), 96'(e.steps));
            checkOutput("hold_total_dist", 96'(total_dist), 96'(e.tdist));
            checkOutput("hold_hit_pos", hit_pos, e.hpos);
            checkOutput("hold_start_ready", 96'(start_ready), 96'(0));
            if (i == 3) begin
                ray_origin = vec(5*ONE, 0, 0);
                start_valid = 1'b1;
            end
            if (i == 4) start_valid = 1'b0;
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_result_valid", 96'(result_valid), 96'(0));
        checkOutput("release_start_ready", 96'(start_ready), 96'(1));
        repeat (4) @(negedge clk);
        checkOutput("ignored_start_requests", 96'(req_total - req0), 96'(0));
        checkOutput("ignored_start_idle", 96'(start_ready), 96'(1));
        waitDrain();

        $display("[TB] reset while waiting for the SDF pipe");
        resp_en = 1'b0;
        applyStimulus(vec(0, 0, -5*ONE), vec(0, 0, ONE));
        n = 0;
        while (!sdf_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_req_seen", 96'(sdf_req_valid), 96'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sdf_dist_valid = 1'b1;
        sdf_dist = '0;
        @(negedge clk);
        sdf_dist_valid = 1'b0;
        @(negedge clk);
        checkResetState("stale");
        repeat (5) @(negedge clk);
        checkResetState("stale_later");
        resp_en = 1'b1;

        $display("[TB] sphere ray after reset");
        sphere_mode = 1'b1;
        exp_q.push_back('{1'b1, 7'd2, 32'h04000000, vec(0, 0, -ONE)});
        applyStimulus(vec(0, 0, -5*ONE), vec(0, 0, ONE));
        waitDrain();
        sphere_mode = 1'b0;

        $display("[TB] random rays");
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < MAXS; i++) dlist[i] = rand_dist();
            org = vec(int'($urandom_range(0, 16*ONE)) - 8*ONE,
                      int'($urandom_range(0, 16*ONE)) - 8*ONE,
                      int'($urandom_range(0, 16*ONE)) - 8*ONE);
            dir = vec(int'($urandom_range(0, 2*ONE)) - ONE,
                      int'($urandom_range(0, 2*ONE)) - ONE,
                      int'($urandom_range(0, 2*ONE)) - ONE);
            e = model_run(org, dir);
            exp_q.push_back(e);
            for (int i = 0; i < int'(e.steps); i++) dist_q.push_back(dlist[i]);
            applyStimulus(org, dir);
        end
        waitDrain();
        checkOutput("unused_distances", 96'(dist_q.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
